// File: rtl/dbus_target.sv
// Debug-bus target: a register file behind a request/response handshake with a
// programmable response latency. Optional DBUS_TARGET_DBG_IRQ_EN drives dbg_irq from reg[16].
module dbus_target #(
  parameter int DEBUG_DATA_BITS = 34,
  parameter int DEBUG_ADDR_BITS = 5,
  parameter int DEBUG_OP_BITS   = 2,
  parameter int DBUS_REQ_BITS   = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS,
  parameter int DBUS_RESP_BITS  = DEBUG_OP_BITS + DEBUG_DATA_BITS,
  parameter int HART_NUM        = 1,
  parameter int RESP_LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dtm_req_valid,
  output logic                      dtm_req_ready,
  input  logic [DBUS_REQ_BITS-1:0]  dtm_req_bits,
  output logic                      dtm_resp_valid,
  input  logic                      dtm_resp_ready,
  output logic [DBUS_RESP_BITS-1:0] dtm_resp_bits,
  input  logic                      tgt_busy,
  output logic [HART_NUM-1:0]       dbg_irq
);

  localparam int DEPTH = 2 ** DEBUG_ADDR_BITS;

  localparam logic [DEBUG_OP_BITS-1:0] OP_NOP   = DEBUG_OP_BITS'(0);
  localparam logic [DEBUG_OP_BITS-1:0] OP_READ  = DEBUG_OP_BITS'(1);
  localparam logic [DEBUG_OP_BITS-1:0] OP_WRITE = DEBUG_OP_BITS'(2);
  localparam logic [DEBUG_OP_BITS-1:0] RC_OK    = DEBUG_OP_BITS'(0);
  localparam logic [DEBUG_OP_BITS-1:0] RC_ERR   = DEBUG_OP_BITS'(2);
  localparam logic [DEBUG_OP_BITS-1:0] RC_BUSY  = DEBUG_OP_BITS'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [DBUS_RESP_BITS-1:0]   resp_q, resp_d;
  logic [DEBUG_DATA_BITS-1:0]  regs_q [DEPTH];

  logic [DEBUG_OP_BITS-1:0]    req_op;
  logic [DEBUG_DATA_BITS-1:0]  req_data;
  logic [DEBUG_ADDR_BITS-1:0]  req_addr;
  logic [DEBUG_DATA_BITS-1:0]  rd_data;
  logic                        accept;
  logic                        we;

  assign req_op   = dtm_req_bits[DEBUG_OP_BITS-1:0];
  assign req_data = dtm_req_bits[DEBUG_OP_BITS+DEBUG_DATA_BITS-1:DEBUG_OP_BITS];
  assign req_addr = dtm_req_bits[DBUS_REQ_BITS-1 -: DEBUG_ADDR_BITS];
  assign rd_data  = regs_q[req_addr];

  // Ready is gated by rst_n so it is low during reset even before the first edge.
  assign dtm_req_ready  = rst_n && (state_q == S_IDLE);
  assign accept         = dtm_req_valid && dtm_req_ready;
  assign we             = accept && !tgt_busy && (req_op == OP_WRITE);
  assign dtm_resp_valid = (state_q == S_RESP);
  assign dtm_resp_bits  = resp_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (tgt_busy) begin
            resp_d = {{DEBUG_DATA_BITS{1'b0}}, RC_BUSY};
          end else begin
            case (req_op)
              OP_NOP:   resp_d = {{DEBUG_DATA_BITS{1'b0}}, RC_OK};
              OP_READ,
              OP_WRITE: resp_d = {rd_data, RC_OK};
              default:  resp_d = {{DEBUG_DATA_BITS{1'b0}}, RC_ERR};
            endcase
          end
          cnt_d   = 4'(RESP_LATENCY);
          state_d = (RESP_LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (dtm_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      if (we) regs_q[req_addr] <= req_data;
    end
  end

`ifdef DBUS_TARGET_DBG_IRQ_EN
  localparam int IRQ_ADDR = 16;
  logic [HART_NUM-1:0] irq_q;

  // Mirrors reg[16] by snooping its write, so the IRQ moves one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) irq_q <= '0;
    else if (we && (int'(req_addr) == IRQ_ADDR)) irq_q <= req_data[HART_NUM-1:0];
  end

  assign dbg_irq = irq_q;
`else
  assign dbg_irq = '0;
`endif

endmodule

// File: tb/tb_dbus_target.sv
// Directed + randomized bench for dbus_target against an array-based reference model.
module tb_dbus_target;

  localparam int DW  = 34;
  localparam int AW  = 5;
  localparam int OW  = 2;
  localparam int RQW = OW + AW + DW;
  localparam int RSW = OW + DW;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [RQW-1:0] req_bits;
  logic           resp_valid;
  logic           resp_ready;
  logic [RSW-1:0] resp_bits;
  logic           tgt_busy;
  logic [0:0]     dbg_irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] model [32];

  always #5 clk = ~clk;

  dbus_target #(
    .DEBUG_DATA_BITS(DW), .DEBUG_ADDR_BITS(AW), .DEBUG_OP_BITS(OW),
    .HART_NUM(1), .RESP_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dtm_req_valid(req_valid), .dtm_req_ready(req_ready), .dtm_req_bits(req_bits),
    .dtm_resp_valid(resp_valid), .dtm_resp_ready(resp_ready), .dtm_resp_bits(resp_bits),
    .tgt_busy(tgt_busy), .dbg_irq(dbg_irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // Expected {data, code} from the op rules; updates the model for writes.
  function automatic logic [RSW-1:0] predict(input logic [1:0] op, input int a,
                                             input logic [DW-1:0] d, input logic busy);
    logic [DW-1:0] old;
    old = model[a];
    if (busy) return {{DW{1'b0}}, 2'b11};
    case (op)
      2'b00: return {{DW{1'b0}}, 2'b00};
      2'b01: return {old, 2'b00};
      2'b10: begin model[a] = d; return {old, 2'b00}; end
      default: return {{DW{1'b0}}, 2'b10};
    endcase
  endfunction

  // One full transaction: accept, measure latency, hold response, handshake.
  task automatic txn(input logic [1:0] op, input int a, input logic [DW-1:0] d,
                     input logic busy, input int hold, input string tag);
    logic [RSW-1:0] exp;
    int lat;
    @(negedge clk);
    check({tag, ".ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_bits  = {AW'(a), d, op};
    tgt_busy  = busy;
    exp = predict(op, a, d, busy);
    @(posedge clk);
    @(negedge clk);
    // Junk request and busy toggling after acceptance must be ignored.
    req_bits = {$urandom, $urandom};
    tgt_busy = $urandom_range(0, 1);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      check({tag, ".ready_wait"}, 64'(req_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(1 + LAT));
    check({tag, ".resp"}, 64'(resp_bits), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(resp_valid), 64'd1);
      check({tag, ".hold_bits"}, 64'(resp_bits), 64'(exp));
      check({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    tgt_busy   = 1'b0;
    check({tag, ".post_valid"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst_n = 1'b0; req_valid = 1'b0; req_bits = '0; resp_ready = 1'b0; tgt_busy = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.req_ready", 64'(req_ready), 64'd0);
    check("rst.resp_valid", 64'(resp_valid), 64'd0);
    check("rst.resp_bits", 64'(resp_bits), 64'd0);
    check("rst.dbg_irq", 64'(dbg_irq), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel.req_ready", 64'(req_ready), 64'd1);

    txn(2'b10, 3, 34'h2DEADBEEF, 1'b0, 0, "wr3");
    txn(2'b01, 3, '0, 1'b0, 0, "rd3");
    txn(2'b00, 3, '0, 1'b0, 5, "nop_hold5");
    txn(2'b10, 5, 34'h1, 1'b1, 0, "busy_wr5");
    txn(2'b01, 5, '0, 1'b0, 0, "rd5");
    txn(2'b11, 0, 34'h3FFFFFFFF, 1'b0, 0, "err0");
    txn(2'b00, 0, 34'h3FFFFFFFF, 1'b0, 0, "nop0");
    txn(2'b10, 31, 34'h3FFFFFFFF, 1'b0, 0, "wr31_max");
    txn(2'b01, 31, '0, 1'b0, 1, "rd31_max");

    txn(2'b10, 16, 34'h1, 1'b0, 0, "wr16");
    @(negedge clk);
`ifdef DBUS_TARGET_DBG_IRQ_EN
    check("irq.set", 64'(dbg_irq), 64'd1);
`else
    check("irq.tied", 64'(dbg_irq), 64'd0);
`endif
    txn(2'b01, 16, '0, 1'b0, 0, "rd16");

    // Reset while in WAIT: operation is dropped and state clears.
    @(negedge clk);
    req_valid = 1'b1;
    req_bits  = {AW'(7), 34'h155, 2'b10};
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    check("mid.req_ready_rst", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("mid.resp_valid_rst", 64'(resp_valid), 64'd0);
    check("mid.irq_rst", 64'(dbg_irq), 64'd0);
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid.no_resp", 64'(resp_valid), 64'd0);
      check("mid.ready_rel", 64'(req_ready), 64'd1);
    end
    txn(2'b01, 7, '0, 1'b0, 0, "rd7_after_rst");
    txn(2'b01, 3, '0, 1'b0, 0, "rd3_after_rst");

    for (int k = 0; k < 40; k++) begin
      rd = {$urandom, $urandom};
      txn(2'($urandom), int'($urandom_range(0, 31)), rd,
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), "rand");
    end
    for (int a = 0; a < 32; a++) txn(2'b01, a, '0, 1'b0, 0, "sweep_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dbus_target.md
DBUS_TARGET -- requirements
Module: dbus_target

Interface
REQ-001 SHALL have parameter DEBUG_DATA_BITS, default 34, Dbus data width.
REQ-002 SHALL have parameter DEBUG_ADDR_BITS, default 5, Dbus address width.
REQ-003 SHALL have parameter DEBUG_OP_BITS, default 2, op/response code width.
REQ-004 SHALL have parameter DBUS_REQ_BITS, default OP+ADDR+DATA, request vector width.
REQ-005 SHALL have parameter DBUS_RESP_BITS, default OP+DATA, response vector width.
REQ-006 SHALL have parameter HART_NUM, default 1, number of debug IRQ outputs.
REQ-007 SHALL have parameter RESP_LATENCY, default 2, legal range 0..15, extra wait cycles before a response.
REQ-008 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-010 SHALL have port dtm_req_valid, input, 1, request valid.
REQ-011 SHALL have port dtm_req_ready, output, 1, request accepted.
REQ-012 SHALL have port dtm_req_bits, input, DBUS_REQ_BITS, request vector: op [OP-1:0], data [OP+DATA-1:OP], addr [top ADDR bits].
REQ-013 SHALL have port dtm_resp_valid, output, 1, response valid.
REQ-014 SHALL have port dtm_resp_ready, input, 1, response accepted.
REQ-015 SHALL have port dtm_resp_bits, output, DBUS_RESP_BITS, response vector: code [OP-1:0], data [OP+DATA-1:OP].
REQ-016 SHALL have port tgt_busy, input, 1, forces a BUSY response for a request accepted while it is high.
REQ-017 SHALL have port dbg_irq, output, HART_NUM, debug IRQ per hart.

Function
REQ-018 SHALL contain 2**DEBUG_ADDR_BITS registers of DEBUG_DATA_BITS each, indexed by the request address.
REQ-019 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; dtm_req_ready = 1 only in IDLE.
REQ-020 SHALL accept a request in a cycle T with valid&ready, capture response code/data at T, then enter WAIT with counter loaded to RESP_LATENCY (0 -> go straight to RESP).
REQ-021 SHALL decrement the counter in WAIT and enter RESP when it reaches 0; dtm_resp_valid first high at T+1+RESP_LATENCY.
REQ-022 SHALL hold dtm_resp_valid and dtm_resp_bits stable in RESP until dtm_resp_ready; at the handshake go to IDLE, so the next acceptance is possible at the handshake cycle +1 at the earliest.
REQ-023 SHALL on op NOP (00) respond OK (00), data 0, no register change.
REQ-024 SHALL on op READ (01) respond OK, data = reg[addr] sampled at T.
REQ-025 SHALL on op WRITE (10) write reg[addr] <= req data at T and respond OK with the pre-write value.
REQ-026 SHALL on op 11 (reserved) respond ERR (10), data 0, no register change.
REQ-027 SHALL, if tgt_busy=1 at T, respond BUSY (11), data 0, no register change, regardless of op.
REQ-028 SHALL ignore dtm_req_valid outside IDLE; tgt_busy changes after T SHALL NOT alter the captured response.
REQ-029 SHALL pass all DEBUG_DATA_BITS of data unmodified; no truncation or sign handling.

Reset
REQ-030 SHALL, with rst_n low at a clock edge, set FSM to IDLE, counter 0, all registers 0, captured response 0; abort any in-flight operation without completing it.
REQ-031 SHALL drive dtm_req_ready=0 while rst_n is low, and 1 from the first cycle after release.
REQ-032 SHALL reset dtm_resp_valid=0, dtm_resp_bits=0, dbg_irq=0.

Configuration
REQ-033 SHALL, with DBUS_TARGET_DBG_IRQ_EN defined, drive dbg_irq = reg[16][HART_NUM-1:0], registered, so it changes the cycle after the write is accepted.
REQ-034 SHALL, without DBUS_TARGET_DBG_IRQ_EN, tie dbg_irq to 0; reg[16] remains a plain storage register.

Verification
REQ-035 SHALL cover: after reset, WRITE addr 3 data 0x2_DEADBEEF -> OK, data 0; READ addr 3 -> OK, data 0x2_DEADBEEF.
REQ-036 SHALL cover: RESP_LATENCY=2, accept at T -> dtm_resp_valid first high at T+3; dtm_resp_ready held low 5 cycles -> resp_valid/bits stable, req_ready=0 throughout.
REQ-037 SHALL cover: tgt_busy=1 with WRITE addr 5 data 0x1 -> BUSY (11), data 0; READ addr 5 -> 0.
REQ-038 SHALL cover: op 11 to addr 0 -> ERR (10), data 0; NOP -> OK, data 0.
REQ-039 SHALL cover: with DBUS_TARGET_DBG_IRQ_EN, WRITE addr 16 data 0x1 -> dbg_irq=1; rst_n low during WAIT -> dbg_irq=0, no response issued, req_ready=1 after release.
